// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES-128 round datapath and key expansion; `AES_ROUND_ABORT_EN adds an abort input
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int DP_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef AES_ROUND_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_last,
    output logic       key_load,
    output logic       key_step,
    output logic [3:0] round_idx,
    output logic [7:0] rcon
);
    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;
    localparam logic [3:0] LAST_CNT = 4'(DP_LATENCY - 1);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, idx_n;
    logic [7:0] rcon_n;
    logic       kill;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
`ifdef AES_ROUND_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif
    assign in_ready = ((state == IDLE) || (state == DONE && out_ready)) && !kill;
    // next state, wait counter, round index and round constant
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = round_idx;
        rcon_n  = rcon;
        case (state)
            IDLE: if (in_valid) begin
                state_n = INIT;
                cnt_n   = 4'd0;
                idx_n   = 4'd0;
                rcon_n  = 8'h00;
            end
            INIT: begin
                state_n = (NUM_ROUNDS > 1) ? ROUND : FINAL;
                cnt_n   = 4'd0;
                idx_n   = 4'd1;
                rcon_n  = 8'h01;
            end
            ROUND, FINAL: if (cnt == LAST_CNT) begin
                cnt_n = 4'd0;
                if (state == FINAL) begin
                    state_n = DONE;
                    idx_n   = 4'd0;
                    rcon_n  = 8'h00;
                end else begin
                    state_n = (round_idx == LAST_RND) ? FINAL : ROUND;
                    idx_n   = round_idx + 4'd1;
                    rcon_n  = xtime(rcon);
                end
            end else begin
                cnt_n = cnt + 4'd1;
            end
            DONE: if (out_ready) begin
                state_n = in_valid ? INIT : IDLE;
                cnt_n   = 4'd0;
                idx_n   = 4'd0;
                rcon_n  = 8'h00;
            end
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            idx_n   = 4'd0;
            rcon_n  = 8'h00;
        end
    end
    // state register; control outputs are registered decodes of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            round_idx   <= 4'd0;
            rcon        <= 8'h00;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            dp_load     <= 1'b0;
            key_load    <= 1'b0;
            dp_round_en <= 1'b0;
            key_step    <= 1'b0;
            dp_last     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            round_idx   <= idx_n;
            rcon        <= rcon_n;
            busy        <= state_n inside {INIT, ROUND, FINAL};
            out_valid   <= state_n == DONE;
            dp_load     <= state_n == INIT;
            key_load    <= state_n == INIT;
            dp_round_en <= (state_n == ROUND || state_n == FINAL) && cnt_n == 4'd0;
            key_step    <= (state_n == ROUND || state_n == FINAL) && cnt_n == 4'd0;
            dp_last     <= state_n == FINAL;
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl (defaults, DP_LATENCY=3, NUM_ROUNDS=14; abort when AES_ROUND_ABORT_EN)
module tb_aes_round_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic iv0 = 1'b0, or0 = 1'b1, iv1 = 1'b0, or1 = 1'b1, iv2 = 1'b0, or2 = 1'b1;
`ifdef AES_ROUND_ABORT_EN
    logic ab0 = 1'b0;
`endif
    logic ir0, ov0, bz0, ld0, re0, lt0, kl0, ks0;
    logic ir1, ov1, bz1, ld1, re1, lt1, kl1, ks1;
    logic ir2, ov2, bz2, ld2, re2, lt2, kl2, ks2;
    logic [3:0] ri0, ri1, ri2;
    logic [7:0] rc0, rc1, rc2;
    logic [7:0] rc_tab [1:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};
    int n_chk = 0, n_fail = 0, pulses = 0;

    always #5 clk = ~clk;

    aes_round_ctrl u0 (.clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .out_valid(ov0),
        .out_ready(or0),
`ifdef AES_ROUND_ABORT_EN
        .abort(ab0),
`endif
        .busy(bz0), .dp_load(ld0), .dp_round_en(re0), .dp_last(lt0), .key_load(kl0),
        .key_step(ks0), .round_idx(ri0), .rcon(rc0));

    aes_round_ctrl #(.DP_LATENCY(3)) u1 (.clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
        .out_valid(ov1), .out_ready(or1),
`ifdef AES_ROUND_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz1), .dp_load(ld1), .dp_round_en(re1), .dp_last(lt1), .key_load(kl1),
        .key_step(ks1), .round_idx(ri1), .rcon(rc1));

    aes_round_ctrl #(.NUM_ROUNDS(14)) u2 (.clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
        .out_valid(ov2), .out_ready(or2),
`ifdef AES_ROUND_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz2), .dp_load(ld2), .dp_round_en(re2), .dp_last(lt2), .key_load(kl2),
        .key_step(ks2), .round_idx(ri2), .rcon(rc2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        check("rst_in_ready0", ir0, 1);
        check("rst_in_ready1", ir1, 1);
        check("rst_in_ready2", ir2, 1);
        check("rst_busy", bz0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_dp_load", ld0, 0);
        check("rst_rcon", rc0, 0);
        check("rst_round_idx", ri0, 0);
        tick;
        reset = 1'b0;
        // single block, defaults
        iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        check("init_dp_load", ld0, 1);
        check("init_key_load", kl0, 1);
        check("init_busy", bz0, 1);
        check("init_round_idx", ri0, 0);
        check("init_rcon", rc0, 0);
        check("init_in_ready", ir0, 0);
        check("init_round_en", re0, 0);
        for (int r = 1; r <= 10; r++) begin
            tick;
            check("rnd_round_en", re0, 1);
            check("rnd_key_step", ks0, 1);
            check("rnd_idx", ri0, r);
            check("rnd_rcon", rc0, rc_tab[r]);
            check("rnd_last", lt0, r == 10);
            check("rnd_dp_load", ld0, 0);
        end
        tick;
        check("done_out_valid", ov0, 1);
        check("done_busy", bz0, 0);
        check("done_round_en", re0, 0);
        check("done_rcon", rc0, 0);
        check("done_in_ready", ir0, 1);
        tick;
        check("idle_out_valid", ov0, 0);
        check("idle_in_ready", ir0, 1);
        // backpressure then back-to-back
        or0 = 1'b0;
        iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        repeat (11) tick;
        iv0 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", ov0, 1);
            check("bp_in_ready", ir0, 0);
            check("bp_busy", bz0, 0);
            tick;
        end
        or0 = 1'b1;
        #1;
        check("bp_release_in_ready", ir0, 1);
        tick;
        iv0 = 1'b0;
        check("b2b_dp_load", ld0, 1);
        check("b2b_out_valid", ov0, 0);
        check("b2b_busy", bz0, 1);
        repeat (11) tick;
        check("b2b_done", ov0, 1);
        tick;
        check("b2b_idle", ir0, 1);
        // asynchronous reset during round 5
        iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        repeat (5) tick;
        check("pre_rst_idx", ri0, 5);
        check("pre_rst_rcon", rc0, 8'h10);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", bz0, 0);
        check("arst_round_en", re0, 0);
        check("arst_idx", ri0, 0);
        check("arst_rcon", rc0, 0);
        check("arst_in_ready", ir0, 1);
        check("arst_out_valid", ov0, 0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            check("arst_no_out_valid", ov0, 0);
        end
        iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        check("post_rst_load", ld0, 1);
        tick;
        check("post_rst_rcon1", rc0, 8'h01);
        check("post_rst_idx1", ri0, 1);
        repeat (9) tick;
        check("post_rst_last", lt0, 1);
        check("post_rst_rcon10", rc0, 8'h36);
        tick;
        check("post_rst_done", ov0, 1);
        tick;
        // DP_LATENCY = 3
        iv1 = 1'b1;
        tick;
        iv1 = 1'b0;
        check("lat3_load", ld1, 1);
        for (int k = 1; k <= 30; k++) begin
            tick;
            check("lat3_round_en", re1, (k - 1) % 3 == 0);
            check("lat3_rcon", rc1, rc_tab[(k - 1) / 3 + 1]);
            check("lat3_idx", ri1, (k - 1) / 3 + 1);
            check("lat3_last", lt1, k > 27);
            check("lat3_out_valid", ov1, 0);
            pulses += int'(re1);
        end
        check("lat3_pulses", pulses, 10);
        tick;
        check("lat3_done", ov1, 1);
        // NUM_ROUNDS = 14
        iv2 = 1'b1;
        tick;
        iv2 = 1'b0;
        check("r14_load", ld2, 1);
        for (int r = 1; r <= 14; r++) begin
            tick;
            check("r14_idx", ri2, r);
            check("r14_rcon", rc2, rc_tab[r]);
            check("r14_last", lt2, r == 14);
        end
        tick;
        check("r14_done", ov2, 1);
`ifdef AES_ROUND_ABORT_EN
        // abort during round 3, then abort while idle
        iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        repeat (3) tick;
        check("abort_pre_idx", ri0, 3);
        ab0 = 1'b1;
        tick;
        ab0 = 1'b0;
        check("abort_busy", bz0, 0);
        check("abort_in_ready", ir0, 1);
        check("abort_round_en", re0, 0);
        check("abort_idx", ri0, 0);
        check("abort_rcon", rc0, 0);
        for (int i = 0; i < 12; i++) begin
            tick;
            check("abort_no_out_valid", ov0, 0);
        end
        ab0 = 1'b1;
        tick;
        check("abort_idle_busy", bz0, 0);
        check("abort_idle_in_ready", ir0, 1);
        check("abort_idle_load", ld0, 0);
        iv0 = 1'b1;
        tick;
        ab0 = 1'b0;
        iv0 = 1'b0;
        check("abort_idle_accept", ld0, 1);
        repeat (11) tick;
        check("abort_idle_done", ov0, 1);
        tick;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
